ram_master: RTL and testbench

RAM_MASTER -- requirements
Module: ram_master

---
 rtl/ram_master.sv | 145 ++++++++++++++
 tb/tb_ram_master.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_master.sv
`default_nettype none
// ============================================================================
//  Module      : ram_master
//  Description : Request-driven master for a synchronous single-port RAM with
//                a shared bidirectional data bus. Performs single-word writes
//                and burst reads of 0..2**LEN_W-1 words, presenting read words
//                as one-cycle RdValid pulses and signalling completion with a
//                one-cycle Done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_address_i,
    input  logic [LEN_W-1:0]  req_length_i,
    input  logic [DATA_W-1:0] req_write_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] address_o,
    inout  wire  [DATA_W-1:0] data_io,
    output logic              read_write_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            state_q;
    logic              ready_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              done_q;
    // Words whose address has not yet been issued, including the current one.
    logic [LEN_W-1:0]  remain_q;
    // Set during the first READ cycle: the RAM has not yet returned a word.
    logic              first_q;

    // Next burst address; the natural ADDR_W-bit overflow gives modulo wrap.
    always_comb begin
        addr_d = addr_q + ADDR_W'(1);
    end

    // Master FSM: all bus and client outputs are registered here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b1;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            remain_q   <= '0;
            first_q    <= 1'b0;
        end else begin
            // Done and RdValid are single-cycle pulses unless re-asserted.
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        if (req_write_i) begin
                            state_q <= ST_WRITE;
                            ready_q <= 1'b0;
                            rw_q    <= 1'b1;
                            addr_q  <= req_address_i;
                            wdata_q <= req_write_data_i;
                        end else if (req_length_i == '0) begin
                            // Empty burst: complete immediately, bus untouched.
                            done_q <= 1'b1;
                        end else begin
                            state_q  <= ST_READ;
                            ready_q  <= 1'b0;
                            addr_q   <= req_address_i;
                            remain_q <= req_length_i;
                            first_q  <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    // RAM captures the word at this edge; release the bus.
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    rw_q    <= 1'b0;
                    done_q  <= 1'b1;
                end
                ST_READ: begin
                    first_q <= 1'b0;
                    // The RAM output lags the address by one cycle.
                    if (!first_q) begin
                        rd_data_q  <= data_io;
                        rd_valid_q <= 1'b1;
                    end
                    if (remain_q == LEN_W'(1)) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        addr_q   <= addr_d;
                        remain_q <= remain_q - LEN_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Collect the final word; its pulse coincides with Done.
                    rd_data_q  <= data_io;
                    rd_valid_q <= 1'b1;
                    done_q     <= 1'b1;
                    ready_q    <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    rw_q    <= 1'b0;
                end
            endcase
        end
    end

    // The master drives the shared bus only during a write cycle.
    assign data_io      = rw_q ? wdata_q : {DATA_W{1'bz}};

    assign req_ready_o  = ready_q;
    assign read_write_o = rw_q;
    assign address_o    = addr_q;
    assign rd_data_o    = rd_data_q;
    assign rd_valid_o   = rd_valid_q;
    assign done_o       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_master
//  Description : Self-checking bench for ram_master with a behavioural RAM and
//                a cycle-schedule model of the expected master outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_master;

    localparam int MAXC = 4096;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr  = '0;
    logic [7:0]  req_len   = '0;
    logic [7:0]  req_wd    = '0;
    logic        req_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic [15:0] address;
    logic        rw;
    wire  [7:0]  data_bus;

    // Preload port into the RAM model (used only while the master is idle).
    logic        pl_en   = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  ram_q = '0;
    logic [7:0]  mdl_mem [0:65535];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Expected behaviour per cycle number (cycle n = interval after posedge n).
    bit        e_busy  [MAXC];
    bit        e_rw    [MAXC];
    bit        e_achk  [MAXC];
    bit [15:0] e_addr  [MAXC];
    bit        e_wchk  [MAXC];
    bit [7:0]  e_wdata [MAXC];
    bit        e_valid [MAXC];
    bit [7:0]  e_vdata [MAXC];
    bit        e_done  [MAXC];

    ram_master #(
        .ADDR_W(16),
        .DATA_W(8),
        .LEN_W (8)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_write_i     (req_write),
        .req_address_i   (req_addr),
        .req_length_i    (req_len),
        .req_write_data_i(req_wd),
        .rd_data_o       (rd_data),
        .rd_valid_o      (rd_valid),
        .done_o          (done),
        .address_o       (address),
        .data_io         (data_bus),
        .read_write_o    (rw)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: registered read when ReadWrite=0, write when ReadWrite=1.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (rw) mem[address] <= data_bus;
        else    ram_q <= mem[address];
    end
    assign data_bus = rw ? 8'bzzzzzzzz : ram_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: on acceptance, lay out the whole transaction on the cycle schedule.
    initial begin
        int c;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int k = cyc; k < cyc + 300; k++) begin
                    if (k < MAXC) begin
                        e_busy[k] = 0; e_rw[k] = 0; e_achk[k] = 0; e_addr[k] = '0;
                        e_wchk[k] = 0; e_wdata[k] = '0; e_valid[k] = 0;
                        e_vdata[k] = '0; e_done[k] = 0;
                    end
                end
            end else begin
                if (pl_en) mdl_mem[pl_addr] = pl_data;
                if (req_valid && !e_busy[cyc]) begin
                    c = cyc + 1;
                    if (req_write) begin
                        e_busy[c] = 1; e_rw[c] = 1;
                        e_achk[c] = 1; e_addr[c] = req_addr;
                        e_wchk[c] = 1; e_wdata[c] = req_wd;
                        e_done[c + 1] = 1;
                        mdl_mem[req_addr] = req_wd;
                    end else if (req_len == 0) begin
                        e_done[c] = 1;
                    end else begin
                        for (int i = 0; i < int'(req_len); i++) begin
                            e_busy[c + i]      = 1;
                            e_achk[c + i]      = 1;
                            e_addr[c + i]      = req_addr + 16'(i);
                            e_valid[c + 2 + i] = 1;
                            e_vdata[c + 2 + i] = mdl_mem[req_addr + 16'(i)];
                        end
                        e_busy[c + int'(req_len)]     = 1;
                        e_done[c + int'(req_len) + 1] = 1;
                    end
                end
            end
        end
    end

    // Compare process: every out-of-reset cycle against the schedule.
    initial begin
        logic [7:0] last_rd;
        int         i;
        last_rd = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_rd = '0;
            end else begin
                i = cyc;
                if (e_valid[i]) last_rd = e_vdata[i];
                chk("m_ready", req_ready, !e_busy[i]);
                chk("m_rw", rw, e_rw[i]);
                chk("m_done", done, e_done[i]);
                chk("m_rdvalid", rd_valid, e_valid[i]);
                chk("m_rddata", rd_data, last_rd);
                if (e_achk[i]) chk("m_addr", address, e_addr[i]);
                if (e_wchk[i]) chk("m_wdata", data_bus, e_wdata[i]);
            end
        end
    end

    // Present a request at a negedge; return at the negedge of transaction cycle 0.
    task automatic send(input logic wr, input logic [15:0] a, input logic [7:0] l,
                        input logic [7:0] d, output int waits);
        logic rdy;
        waits     = 0;
        req_write = wr;
        req_addr  = a;
        req_len   = l;
        req_wd    = d;
        req_valid = 1'b1;
        forever begin
            rdy = req_ready;
            @(posedge clk);
            if (rdy) break;
            waits++;
            if (waits > 40) begin
                chk("accept_timeout", {31'b0, rdy}, 1);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        int w;
        int seen;
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_rw", rw, 0);
        chk("rst_addr", address, 16'h0000);
        chk("rst_rddata", rd_data, 8'h00);
        chk("rst_rdvalid", rd_valid, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        preload(16'h0100, 8'h11);
        preload(16'h0101, 8'h22);
        preload(16'h0102, 8'h33);
        preload(16'h0103, 8'h44);
        preload(16'hFFFE, 8'hA1);
        preload(16'hFFFF, 8'hA2);
        preload(16'h0000, 8'hA3);
        preload(16'h0200, 8'h3C);
        preload(16'h0300, 8'h05);
        preload(16'h0301, 8'h06);

        // Single write then read-back, issued back-to-back in the Done cycle.
        send(1'b1, 16'h0010, 8'd0, 8'hA5, w);
        chk("wr_rw", rw, 1);
        chk("wr_addr", address, 16'h0010);
        chk("wr_data", data_bus, 8'hA5);
        chk("wr_ready", req_ready, 0);
        @(negedge clk);
        chk("wr_done", done, 1);
        chk("wr_rw_after", rw, 0);
        send(1'b0, 16'h0010, 8'd1, 8'h00, w);
        chk("rd1_b2b_wait", w, 0);
        chk("rd1_addr", address, 16'h0010);
        @(negedge clk);
        chk("rd1_valid_drain", rd_valid, 0);
        @(negedge clk);
        chk("rd1_valid", rd_valid, 1);
        chk("rd1_data", rd_data, 8'hA5);
        chk("rd1_done", done, 1);
        @(negedge clk);

        // Four-word burst, with a stray request pulsed mid-burst.
        send(1'b0, 16'h0100, 8'd4, 8'h00, w);
        chk("b4_addr0", address, 16'h0100);
        @(negedge clk);
        chk("b4_addr1", address, 16'h0101);
        chk("b4_valid_c1", rd_valid, 0);
        req_write = 1'b1; req_addr = 16'h0200; req_wd = 8'h77; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("b4_w0_valid", rd_valid, 1);
        chk("b4_w0", rd_data, 8'h11);
        @(negedge clk);
        chk("b4_w1", rd_data, 8'h22);
        @(negedge clk);
        chk("b4_w2", rd_data, 8'h33);
        chk("b4_done_early", done, 0);
        @(negedge clk);
        chk("b4_w3", rd_data, 8'h44);
        chk("b4_w3_valid", rd_valid, 1);
        chk("b4_done", done, 1);

        // Wrapping burst accepted in the Done cycle.
        send(1'b0, 16'hFFFE, 8'd3, 8'h00, w);
        chk("wrap_b2b_wait", w, 0);
        chk("wrap_addr0", address, 16'hFFFE);
        @(negedge clk);
        chk("wrap_addr1", address, 16'hFFFF);
        @(negedge clk);
        chk("wrap_addr2", address, 16'h0000);
        chk("wrap_w0", rd_data, 8'hA1);
        @(negedge clk);
        chk("wrap_w1", rd_data, 8'hA2);
        @(negedge clk);
        chk("wrap_w2", rd_data, 8'hA3);
        chk("wrap_done", done, 1);
        @(negedge clk);

        // Stray write during the burst must not have reached the RAM.
        send(1'b0, 16'h0200, 8'd1, 8'h00, w);
        repeat (2) @(negedge clk);
        chk("ignored_req_data", rd_data, 8'h3C);
        @(negedge clk);

        // Zero-length read.
        send(1'b0, 16'h1234, 8'd0, 8'h00, w);
        chk("l0_done", done, 1);
        chk("l0_valid", rd_valid, 0);
        chk("l0_rw", rw, 0);
        chk("l0_ready", req_ready, 1);
        @(negedge clk);
        chk("l0_done_off", done, 0);

        // Reset asserted during cycle 2 of an eight-word burst.
        send(1'b0, 16'h0300, 8'd8, 8'h00, w);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", req_ready, 1);
        chk("arst_rw", rw, 0);
        chk("arst_addr", address, 16'h0000);
        chk("arst_rddata", rd_data, 8'h00);
        chk("arst_rdvalid", rd_valid, 0);
        chk("arst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (rd_valid || done) seen++;
        end
        chk("arst_no_activity", seen, 0);
        send(1'b1, 16'h0400, 8'd0, 8'h5A, w);
        chk("arst_accept_wait", w, 0);
        @(negedge clk);
        send(1'b0, 16'h0400, 8'd1, 8'h00, w);
        repeat (2) @(negedge clk);
        chk("arst_readback", rd_data, 8'h5A);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
